// File: rtl/cpu_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_controller: instruction register, decoder and Moore sequencing FSM    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic        loadc,
    output logic        loads,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] datapath_in
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    assign datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // IR capture and the start decision share the WAIT edge, so DECODE sees the new word.
    always_comb begin
        ir_d    = ir_q;
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (load) ir_d = in;
                if (s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)                state_d = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn) state_d = S_GET_B;
                else if (is_alu)               state_d = S_GET_A;
                else                           state_d = S_WAIT;
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Controls are gated by reset so nothing can be written on the reset edge.
    always_comb begin
        w        = 1'b0;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        if (!reset) begin
            case (state_q)
                S_WAIT: w = 1'b1;
                S_WRITE_IMM: begin
                    vsel     = 1'b1;
                    write    = 1'b1;
                    writenum = rn;
                end
                S_GET_A: begin
                    readnum = rn;
                    loada   = 1'b1;
                end
                S_GET_B: begin
                    readnum = rm;
                    loadb   = 1'b1;
                end
                S_ALU: begin
                    shift = sh;
                    ALUop = is_alu ? op : 2'b00;
                    asel  = is_mov_reg || is_mvn;
                    loadc = !is_cmp;
                    loads = is_cmp;
                end
                S_WRITE_REG: begin
                    write    = 1'b1;
                    writenum = rd;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
